// File: rtl/prog_ctr_gen_pkg.sv
// Shared types, default sizes and helpers for the program counter generator.
package prog_ctr_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_ABS,
    PC_REL,
    PC_CALL,
    PC_RET
  } pc_sel_e;

  localparam int unsigned DEF_PW        = 8;
  localparam int unsigned DEF_STALL_DIV = 4;
  localparam int unsigned DEF_DEPTH     = 4;

  // Sign-extend the low w bits of off (1 <= w <= 32) to a full 32-bit word.
  function automatic logic [31:0] sext_off(input logic [31:0] off, input int unsigned w);
    int unsigned sh;
    sh = 32 - w;
    return $unsigned(($signed(off << sh)) >>> sh);
  endfunction

endpackage

// File: rtl/prog_ctr_gen_if.sv
// Decoder-to-PC bundle: branch/call/return strobes in, PC and stack status out.
interface prog_ctr_gen_if
  import prog_ctr_pkg::*;
#(
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned DEPTH = DEF_DEPTH
) ();

  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic          Start;
  logic          StallCtr;
  logic          Jen;
  logic          Zero;
  logic          Rel;
  logic          Call;
  logic          Ret;
  logic [PW-1:0] Jump;
  logic [PW-1:0] PC;
  logic [DW-1:0] Depth;
  logic          Ovf;
  logic          Unf;

  modport master (
    output Start, StallCtr, Jen, Zero, Rel, Call, Ret, Jump,
    input  PC, Depth, Ovf, Unf
  );

  modport slave (
    input  Start, StallCtr, Jen, Zero, Rel, Call, Ret, Jump,
    output PC, Depth, Ovf, Unf
  );

endinterface

// File: rtl/prog_ctr_gen_ret_stack.sv
// Return-address LIFO; the caller never issues push and pop in the same cycle.
module ret_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned DW      = $clog2(DEPTH + 1);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRIES = 1 << AW;

  logic [W-1:0]  mem [ENTRIES];
  logic [DW-1:0] depth_q;
  logic [AW-1:0] top_idx;

  // Entries above the current depth are never read, so the modular
  // subtraction on the low address bits always lands on the top entry.
  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];
  assign depth   = depth_q;
  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);

  // NOTE: storage is deliberately left out of reset; depth_q alone
  // defines which entries are valid, and an unreset array stays plain RAM.
  always_ff @(posedge Clk) begin
    if (push) mem[depth_q[AW-1:0]] <= din;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     depth_q <= '0;
    else if (push) depth_q <= depth_q + DW'(1);
    else if (pop)  depth_q <= depth_q - DW'(1);
  end

endmodule

// File: rtl/prog_ctr_gen.sv
// Program counter with stall divider, absolute/relative branches and a
// hardware call/return stack with sticky overflow/underflow flags.
module prog_ctr_gen
  import prog_ctr_pkg::*;
#(
  parameter int unsigned   PW        = DEF_PW,
  parameter int unsigned   STALL_DIV = DEF_STALL_DIV,
  parameter int unsigned   DEPTH     = DEF_DEPTH,
  parameter logic [PW-1:0] RESET_PC  = '0
) (
  input logic          Clk,
  input logic          Reset,
  prog_ctr_gen_if.slave bus
);

  localparam int unsigned CW = (STALL_DIV > 1) ? $clog2(STALL_DIV) : 1;
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic [CW-1:0] ct_q;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] pc_nxt;
  logic [PW-1:0] stk_top;
  logic [DW-1:0] stk_depth;
  logic [31:0]   rel_off;
  logic          stk_full, stk_empty;
  logic          push, pop, ovf_set, unf_set;
  logic          ovf_q, unf_q;
  logic          adv;
  pc_sel_e       sel;

  assign adv     = !bus.Start && (!bus.StallCtr || ct_q == '0);
  assign pc_inc  = pc_q + PW'(1);
  assign rel_off = sext_off(32'(bus.Jump), PW);

  // NOTE: every output gets a default first so no path leaves one unassigned
  // and infers a latch.
  always_comb begin
    sel     = PC_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (adv) begin
      if (bus.Ret) begin
        sel     = stk_empty ? PC_INC : PC_RET;
        pop     = !stk_empty;
        unf_set = stk_empty;
      end else if (bus.Call) begin
        sel     = PC_CALL;
        push    = !stk_full;
        ovf_set = stk_full;
      end else if (bus.Jen && bus.Zero) begin
        sel = bus.Rel ? PC_REL : PC_ABS;
      end else begin
        sel = PC_INC;
      end
    end
  end

  always_comb begin
    pc_nxt = pc_q;
    unique case (sel)
      PC_HOLD: pc_nxt = pc_q;
      PC_INC:  pc_nxt = pc_inc;
      PC_ABS:  pc_nxt = bus.Jump;
      PC_REL:  pc_nxt = pc_q + rel_off[PW-1:0];
      PC_CALL: pc_nxt = bus.Jump;
      PC_RET:  pc_nxt = stk_top;
      default: pc_nxt = pc_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ct_q <= '0;
    end else if (!bus.Start) begin
      if (bus.StallCtr) ct_q <= (ct_q == CW'(STALL_DIV - 1)) ? '0 : ct_q + CW'(1);
      else              ct_q <= '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  ret_stack #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.PC    = pc_q;
  assign bus.Depth = stk_depth;
  assign bus.Ovf   = ovf_q;
  assign bus.Unf   = unf_q;

endmodule

// File: doc/prog_ctr_gen.md
Name: prog_ctr_gen

Overview:
Parametrised next-generation program counter for the single-cycle/multi-cycle core. It generalises PC width and the stall divide ratio, and adds relative branches plus a hardware call/return stack. It sits between the control decoder, which supplies the jump, call and return strobes, and instruction memory, which is addressed by PC.

Parameters:
PW, 8, PC width in bits; also the width of the Jump operand.
STALL_DIV, 4, while stalled, PC advances once every STALL_DIV cycles; legal range 1..16 (1 means stall has no effect).
DEPTH, 4, return-stack entries; legal range 1..16.
RESET_PC, 0, PC value loaded on reset.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  hold: freezes PC, stall counter, stack and flags.
StallCtr  input  1  multi-cycle stall mode request.
Jen  input  1  conditional branch enable.
Zero  input  1  ALU zero flag; a branch is taken when Jen & Zero.
Rel  input  1  1 = branch target is PC + signed Jump; 0 = absolute Jump.
Call  input  1  unconditional call to absolute Jump; pushes PC+1.
Ret  input  1  return: pops the stack into PC.
Jump  input  PW  branch target or signed offset.
PC  output  PW  current program counter.
Depth  output  clog2(DEPTH+1)  number of valid stack entries.
Ovf  output  1  sticky: a call was made while the stack was full.
Unf  output  1  sticky: a return was made while the stack was empty.

Behaviour:
- Reset (asynchronous) sets: PC=RESET_PC, stall counter ct=0, Depth=0, Ovf=0, Unf=0, stack contents don't-care. Reset asserted mid-stall or mid-call aborts immediately, with no partial update.
- Advance enable adv = !Start & (!StallCtr | ct==0).
- Stall counter:
  - Start=1: ct holds.
  - StallCtr=1: ct <= (ct==STALL_DIV-1) ? 0 : ct+1.
  - StallCtr=0: ct <= 0.
  - Result: the first stalled cycle advances, then STALL_DIV-1 cycles hold, repeating.
- Next-PC selection when adv=1, in priority order:
  1. Ret & Depth>0: PC <= top of stack; Depth-1.
  2. Ret & Depth==0: PC <= PC+1; Unf <= 1.
  3. Call & Depth<DEPTH: push PC+1; PC <= Jump; Depth+1.
  4. Call & Depth==DEPTH: PC <= Jump; push dropped; Ovf <= 1; Depth unchanged.
  5. Jen & Zero & Rel: PC <= PC + sign-extended Jump.
  6. Jen & Zero & !Rel: PC <= Jump.
  7. Otherwise: PC <= PC+1.
- When adv=0: PC, stack, Depth, Ovf and Unf all hold. Strobes presented in that cycle are ignored; the decoder must hold them until the advancing cycle.
- All PC arithmetic is modulo 2^PW. PC=2^PW-1 increments to 0. The pushed return address PC+1 wraps the same way. Relative targets wrap in both directions.
- Call and Ret asserted together: Ret wins and Call is ignored. Call outranks a conditional branch in the same cycle.
- Latency: a change on the inputs is visible on PC one Clk edge later. PC is a direct register output with no combinational path from inputs.
- Ovf and Unf clear only on Reset.

Decomposition:
- prog_ctr_pkg holds:
  - the pc_sel_e enum: PC_HOLD, PC_INC, PC_ABS, PC_REL, PC_CALL, PC_RET;
  - default PW, STALL_DIV and DEPTH constants;
  - a sign-extension function for offsets.
- Sub-module ret_stack: a parametrised LIFO with push, pop, top, depth, full and empty; push and pop together are never issued. The top level holds the stall counter, the select priority logic and the sticky flags.

Test Plan:
All scenarios use PW=8, STALL_DIV=4, DEPTH=4, RESET_PC=0.
1. Reset, then 5 idle cycles -> PC 0,1,2,3,4,5. Assert Reset mid-cycle -> PC=0 asynchronously, before the next edge.
2. StallCtr=1 for 8 cycles starting at PC=10 -> PC sequence 11,11,11,11,12,12,12,12. Drop StallCtr -> PC increments every cycle with ct=0. With Start=1 during a stall, PC and ct freeze, and the sequence resumes on release.
3. PC=0x20, Jen=1, Zero=1, Rel=1, Jump=0xFC -> PC=0x1C. Rel=0, Jump=0x80 -> PC=0x80. Jen=1, Zero=0 -> PC=0x81.
4. Nested calls from PC=0x10, 0x40 and 0x50 to targets 0x40, 0x50, 0x60 -> Depth=3. Three Rets -> PC 0x51, 0x41, 0x11; Depth=0; Ovf=Unf=0.
5. Five calls starting at PC=0x00 -> fifth call jumps to Jump but leaves Depth=4 with Ovf=1. Five Rets -> fifth Ret gives PC=previous PC+1 with Unf=1. Both flags stay set until Reset.
6. Call=Ret=1 with Depth=1 and top=0x33 -> PC=0x33, Depth=0, no push. PC=0xFF with Call and Jump=0x05 -> pushed value 0x00, and a later Ret gives PC=0x00.
